// File: rtl/mem_issue_queue.sv
// In-order issue queue for memory ops: entries wait on source-tag wakeups,
// and stores additionally wait until they are the oldest in-flight instruction.
module mem_issue_queue #(
  parameter int DEPTH     = 16,
  parameter int PREG_W    = 6,
  parameter int ROB_W     = 5,
  parameter int PAYLOAD_W = 96,
  parameter int NUM_WAKE  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic                       enq_is_store,
  input  logic [PREG_W-1:0]          enq_ps1,
  input  logic [PREG_W-1:0]          enq_ps2,
  input  logic                       enq_ps1_rdy,
  input  logic                       enq_ps2_rdy,
  input  logic [ROB_W-1:0]           enq_rob,
  input  logic [PAYLOAD_W-1:0]       enq_payload,
  input  logic [NUM_WAKE-1:0]        wake_valid,
  input  logic [NUM_WAKE*PREG_W-1:0] wake_preg,
  input  logic [ROB_W-1:0]           rob_head,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic                       iss_is_store,
  output logic [ROB_W-1:0]           iss_rob,
  output logic [PAYLOAD_W-1:0]       iss_payload,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]     head_reg, tail_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [DEPTH-1:0]     valid_reg, rdy1_reg, rdy2_reg;
  logic [DEPTH-1:0]     hit1, hit2;
  logic [PREG_W-1:0]    ps1_mem [DEPTH];
  logic [PREG_W-1:0]    ps2_mem [DEPTH];
  logic                 store_mem [DEPTH];
  logic [ROB_W-1:0]     rob_mem [DEPTH];
  logic [PAYLOAD_W-1:0] payload_mem [DEPTH];

  logic full, empty, do_enq, do_deq, enq_rdy1, enq_rdy2;

  function automatic logic wake_match(input logic [NUM_WAKE-1:0]        v,
                                      input logic [NUM_WAKE*PREG_W-1:0] p,
                                      input logic [PREG_W-1:0]          tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WAKE; k++) begin
      if (v[k] && p[k*PREG_W +: PREG_W] == tag) hit = 1'b1;
    end
    return hit;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wake
      assign hit1[gi] = wake_match(wake_valid, wake_preg, ps1_mem[gi]);
      assign hit2[gi] = wake_match(wake_valid, wake_preg, ps2_mem[gi]);
    end
  endgenerate

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign enq_ready = !full;
  assign count     = count_reg;

  assign iss_is_store = store_mem[head_reg];
  assign iss_rob      = rob_mem[head_reg];
  assign iss_payload  = payload_mem[head_reg];

  // Stores may only leave once they are the oldest instruction in the machine.
  assign iss_valid = !empty && rdy1_reg[head_reg] && rdy2_reg[head_reg] &&
                     (!store_mem[head_reg] || rob_mem[head_reg] == rob_head) && !flush;

  assign do_enq = enq_valid && enq_ready && !flush;
  assign do_deq = iss_valid && iss_ready;

  // Tag 0 is the hardwired zero register and never needs a wakeup.
  assign enq_rdy1 = enq_ps1_rdy || (enq_ps1 == '0) || wake_match(wake_valid, wake_preg, enq_ps1);
  assign enq_rdy2 = enq_ps2_rdy || (enq_ps2 == '0) || wake_match(wake_valid, wake_preg, enq_ps2);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
      rdy1_reg  <= '0;
      rdy2_reg  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_reg[i] && hit1[i]) rdy1_reg[i] <= 1'b1;
        if (valid_reg[i] && hit2[i]) rdy2_reg[i] <= 1'b1;
      end
      // Head and tail never coincide when both fire: that needs 0 < count < DEPTH.
      if (do_deq) begin
        valid_reg[head_reg] <= 1'b0;
        rdy1_reg[head_reg]  <= 1'b0;
        rdy2_reg[head_reg]  <= 1'b0;
        head_reg            <= head_reg + PTR_W'(1);
      end
      if (do_enq) begin
        valid_reg[tail_reg] <= 1'b1;
        rdy1_reg[tail_reg]  <= enq_rdy1;
        rdy2_reg[tail_reg]  <= enq_rdy2;
        tail_reg            <= tail_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(do_enq) - CNT_W'(do_deq);
    end
  end

  // Entry contents are only meaningful while valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (do_enq && !rst) begin
      ps1_mem[tail_reg]     <= enq_ps1;
      ps2_mem[tail_reg]     <= enq_ps2;
      store_mem[tail_reg]   <= enq_is_store;
      rob_mem[tail_reg]     <= enq_rob;
      payload_mem[tail_reg] <= enq_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(do_enq && full));
      assert (!(do_deq && empty));
      assert (count_reg <= CNT_W'(DEPTH));
    end
  end

endmodule

// File: doc/mem_issue_queue.md
MEM_ISSUE_QUEUE -- requirements
Module: mem_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-002 SHALL have parameter PREG_W, default 6, physical-register tag width.
REQ-003 SHALL have parameter ROB_W, default 5, ROB index width.
REQ-004 SHALL have parameter PAYLOAD_W, default 96, opaque payload width (funct3, imm, pc, arch regs, order).
REQ-005 SHALL have parameter NUM_WAKE, default 2, wakeup broadcast port count.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 flush  in  1  discard all entries (mispredict).
REQ-009 enq_valid  in  1 / enq_ready  out  1  enqueue handshake.
REQ-010 enq_is_store  in  1  entry is a store (else load).
REQ-011 enq_ps1, enq_ps2  in  PREG_W each  source physical tags.
REQ-012 enq_ps1_rdy, enq_ps2_rdy  in  1 each  source ready at dispatch.
REQ-013 enq_rob  in  ROB_W / enq_payload  in  PAYLOAD_W  entry ROB index and payload.
REQ-014 wake_valid  in  NUM_WAKE / wake_preg  in  NUM_WAKE*PREG_W  tag broadcasts, port k at bits [k*PREG_W +: PREG_W].
REQ-015 rob_head  in  ROB_W  current ROB head index.
REQ-016 iss_valid  out  1 / iss_ready  in  1  issue handshake.
REQ-017 iss_is_store  out  1, iss_rob  out  ROB_W, iss_payload  out  PAYLOAD_W  head entry fields.
REQ-018 count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-019 SHALL be a strict in-order circular FIFO: head/tail pointers $clog2(DEPTH) bits, wrap DEPTH-1 -> 0.
REQ-020 SHALL track occupancy with count so all DEPTH slots are usable; empty = count 0, full = count DEPTH.
REQ-021 enq_ready SHALL equal !full, independent of same-cycle dequeue (no comb path iss_ready -> enq_ready).
REQ-022 Enqueue occurs when enq_valid & enq_ready & !flush; entry written at tail, tail+1.
REQ-023 Each entry SHALL hold rdy1/rdy2 bits; at enqueue rdyN = enq_psN_rdy | (enq_psN == 0) | any same-cycle wake match on enq_psN.
REQ-024 Each cycle, valid entry rdyN SHALL set when any wake_valid[k] with wake_preg[k] == psN; bits never clear while entry valid.
REQ-025 iss_valid SHALL be combinational: !empty & head rdy1 & rdy2 & (!head store | rob_head == head rob) & !flush.
REQ-026 iss_is_store/iss_rob/iss_payload SHALL reflect head entry whenever !empty; don't-care when empty.
REQ-027 Dequeue occurs when iss_valid & iss_ready; head+1.
REQ-028 Loads SHALL issue without ROB-head check; never reorder past an older unissued store or load.
REQ-029 count next = count + enq - deq; simultaneous enqueue and dequeue leaves count unchanged.
REQ-030 When full and dequeuing, enqueue SHALL still be refused that cycle (per REQ-021).
REQ-031 flush SHALL, next cycle, set head = tail = 0, count = 0, all entry valid/ready bits 0; enq and deq in flush cycle ignored.
REQ-032 Payload storage need not be cleared on flush/reset; only valid/ready/pointer state cleared.
REQ-033 count SHALL never exceed DEPTH nor underflow; assertion fires on enq when full or deq when empty.

Reset
REQ-034 On rst, next cycle: head = tail = 0, count = 0, all valid/rdy bits 0, iss_valid = 0, enq_ready = 1.
REQ-035 rst SHALL take priority over flush, enqueue, dequeue and wakeup.

Verification
REQ-036 Reset, enqueue 16 loads with rdy = 1 and iss_ready = 0 -> count = 16, enq_ready = 0; 17th enq refused; then iss_ready = 1 drains 16 in order, count = 0.
REQ-037 Enqueue store rob = 5 with both rdy, rob_head = 3 -> iss_valid = 0; rob_head = 5 -> iss_valid = 1, dequeues next edge.
REQ-038 Enqueue load ps1 = 9 not ready; wake_preg[1] = 9 same cycle as enqueue -> rdy1 set, iss_valid = 1 next cycle.
REQ-039 Fill to 16, hold iss_ready = 1 and enq_valid = 1 -> one dequeue, no enqueue per full cycle; after head/tail wrap past 15, order preserved.
REQ-040 Queue with 7 entries, flush with enq_valid = 1 -> next cycle count = 0, iss_valid = 0, enqueued entry discarded.
REQ-041 Entry with ps2 = 0, enq_ps2_rdy = 0 -> treated ready; issues once ps1 woken.
